dma_engine: RTL and testbench

- Single-channel word-copy DMA with two bus faces.
- Bus responder for configuration (req/resp/fault protocol, 4-byte access only).
- Bus initiator on the same protocol, issuing read-then-write transactions that copy LEN 32-bit words from SRC to DST.
- Completion or error raises level output dma_int, wired to one ext_int_from input of the external interrupt controller (the controller's posedge detect sees the 0->1 rise).

---
 rtl/dma_engine_pkg.sv | 41 ++++
 rtl/dma_engine_if.sv | 27 ++
 rtl/dma_engine_bus_initiator.sv | 115 +++++++++++
 rtl/dma_engine.sv | 118 +++++++++++
 tb/tb_dma_engine.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_engine_pkg.sv
// Shared constants, FSM encoding and config decode helper
// for the single-channel word-copy DMA.
package dma_engine_pkg;

  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;
  localparam int DMA_VA_WIDTH  = 4;

  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  localparam logic [DMA_VA_WIDTH-1:0] DMA_SRC  = 4'h0;
  localparam logic [DMA_VA_WIDTH-1:0] DMA_DST  = 4'h4;
  localparam logic [DMA_VA_WIDTH-1:0] DMA_LEN  = 4'h8;
  localparam logic [DMA_VA_WIDTH-1:0] DMA_CTRL = 4'hC;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERR   = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_ERR     = 3'd5
  } dma_state_e;

  function automatic logic cfg_invalid(
    input logic [DMA_VA_WIDTH-1:0]  addr,
    input logic [BUS_ACC_WIDTH-1:0] acc
  );
    return (acc != BUS_ACC_4B) ||
           (addr[1:0] != 2'b00) ||
           (addr > DMA_CTRL);
  endfunction

endpackage

// File: rtl/dma_engine_if.sv
// req/resp/fault bus face; the config port narrows the address
// through AW, the initiator port keeps the full bus width.
interface dma_engine_if #(
  parameter int AW = dma_engine_pkg::BUS_WIDTH
);
  import dma_engine_pkg::*;

  logic [AW-1:0]            addr;
  logic                     w_rb;
  logic [BUS_ACC_WIDTH-1:0] acc;
  logic [BUS_WIDTH-1:0]     rdata;
  logic [BUS_WIDTH-1:0]     wdata;
  logic                     req;
  logic                     resp;
  logic                     fault;

  modport master (
    output addr, w_rb, acc, wdata, req,
    input  rdata, resp, fault
  );

  modport slave (
    input  addr, w_rb, acc, wdata, req,
    output rdata, resp, fault
  );

endinterface

// File: rtl/dma_engine_bus_initiator.sv
// Copy FSM and initiator-port registers: read a word from SRC,
// write it to DST, strobe the top to advance the working registers.
module dma_engine_bus_initiator
  import dma_engine_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [BUS_WIDTH-1:0] src_i,
  input  logic [BUS_WIDTH-1:0] dst_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  dma_engine_if.master         m,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 adv_o
);

  dma_state_e           state_q, state_d;
  logic                 req_q, req_d;
  logic                 w_rb_q, w_rb_d;
  logic [BUS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      w_rb_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      w_rb_q  <= w_rb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // req is raised on entry to a REQ state so it lines up with it
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    w_rb_d  = w_rb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_o  = 1'b0;
    err_o   = 1'b0;
    adv_o   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d = ST_RD_REQ;
            req_d   = 1'b1;
            w_rb_d  = 1'b0;
            addr_d  = src_i;
          end else begin
            done_o = 1'b1;
          end
        end
      end
      ST_RD_REQ: begin
        state_d = m.fault ? ST_ERR : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (m.resp) begin
          state_d = ST_WR_REQ;
          req_d   = 1'b1;
          w_rb_d  = 1'b1;
          addr_d  = dst_i;
          wdata_d = m.rdata;
        end
      end
      ST_WR_REQ: begin
        state_d = m.fault ? ST_ERR : ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (m.resp) begin
          adv_o = 1'b1;
          if (len_i == LEN_WIDTH'(1)) begin
            state_d = ST_IDLE;
            done_o  = 1'b1;
          end else begin
            // src_i advances on this same edge
            state_d = ST_RD_REQ;
            req_d   = 1'b1;
            w_rb_d  = 1'b0;
            addr_d  = src_i + 32'd4;
          end
        end
      end
      ST_ERR: begin
        err_o   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q == ST_RD_REQ) ||
                  (state_q == ST_RD_WAIT) ||
                  (state_q == ST_WR_REQ) ||
                  (state_q == ST_WR_WAIT);

  assign m.req   = req_q;
  assign m.w_rb  = w_rb_q;
  assign m.addr  = addr_q;
  assign m.wdata = wdata_q;
  assign m.acc   = BUS_ACC_4B;

endmodule

// File: rtl/dma_engine.sv
// Single-channel DMA top: config responder, live SRC/DST/LEN
// working registers, status flags and the interrupt level.
module dma_engine
  import dma_engine_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rstn,
  dma_engine_if.slave  s,
  dma_engine_if.master m,
  output logic         dma_int
);

  logic [BUS_WIDTH-1:0] src_q, src_d;
  logic [BUS_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 resp_q, resp_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                 int_q, int_d;

  logic                 busy, ini_done, ini_err, adv;
  logic                 cfg_ok, cfg_wr, ctrl_wr;
  logic                 start, clr;
  logic [BUS_WIDTH-1:0] rd_val;

  assign s.fault = s.req & cfg_invalid(s.addr, s.acc);
  assign cfg_ok  = s.req & ~cfg_invalid(s.addr, s.acc);
  assign cfg_wr  = cfg_ok & s.w_rb;
  assign ctrl_wr = cfg_wr & (s.addr == DMA_CTRL);
  assign start   = ctrl_wr & s.wdata[CTRL_START];
  assign clr     = ctrl_wr & s.wdata[CTRL_CLR];

  dma_engine_bus_initiator #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_init (
    .clk     (clk),
    .rstn    (rstn),
    .start_i (start),
    .src_i   (src_q),
    .dst_i   (dst_q),
    .len_i   (len_q),
    .m       (m),
    .busy_o  (busy),
    .done_o  (ini_done),
    .err_o   (ini_err),
    .adv_o   (adv)
  );

  always_comb begin
    rd_val = '0;
    unique case (s.addr)
      DMA_SRC:  rd_val = src_q;
      DMA_DST:  rd_val = dst_q;
      DMA_LEN:  rd_val = BUS_WIDTH'(len_q);
      DMA_CTRL: begin
        rd_val[STAT_BUSY] = busy;
        rd_val[STAT_DONE] = done_q;
        rd_val[STAT_ERR]  = err_q;
      end
      default:  rd_val = '0;
    endcase
  end

  // CLR is folded in before the initiator's done/err strobes
  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    resp_d  = cfg_ok;
    rdata_d = rdata_q;
    if (cfg_ok & ~s.w_rb) rdata_d = rd_val;
    if (adv) begin
      src_d = src_q + 32'd4;
      dst_d = dst_q + 32'd4;
      len_d = len_q - LEN_WIDTH'(1);
    end else if (cfg_wr & ~busy) begin
      unique case (1'b1)
        s.addr == DMA_SRC: src_d = {s.wdata[31:2], 2'b00};
        s.addr == DMA_DST: dst_d = {s.wdata[31:2], 2'b00};
        s.addr == DMA_LEN: len_d = s.wdata[LEN_WIDTH-1:0];
        default: ;
      endcase
    end
    done_d = (done_q & ~clr) | ini_done;
    err_d  = (err_q & ~clr) | ini_err;
    int_d  = done_d | err_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      int_q   <= 1'b0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      int_q   <= int_d;
    end
  end

  assign s.resp  = resp_q;
  assign s.rdata = rdata_q;
  assign dma_int = int_q;

endmodule

// File: tb/tb_dma_engine.sv
// Scoreboard bench for dma_engine: directed config traffic and a
// memory responder; monitors pop expected bus transactions.
module tb_dma_engine;
  import dma_engine_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic dma_int;

  always #5 clk = ~clk;

  dma_engine_if #(.AW(DMA_VA_WIDTH)) s_if ();
  dma_engine_if m_if ();

  dma_engine #(.LEN_WIDTH(16)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s       (s_if),
    .m       (m_if),
    .dma_int (dma_int)
  );

  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
  } mtx_t;

  typedef struct packed {
    logic        rd;
    logic [31:0] data;
  } stx_t;

  int   n_chk = 0;
  int   n_fail = 0;
  mtx_t exp_m[$];
  stx_t exp_s[$];
  mtx_t me;
  stx_t se;

  logic [31:0] mem [bit [31:0]];
  int          rdelay = 1;
  logic        flt_en = 1'b0;
  logic [31:0] flt_addr = 32'h0;

  assign m_if.fault = m_if.req & flt_en & ~m_if.w_rb &
                      (m_if.addr == flt_addr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // memory responder
  logic        r_w;
  logic [31:0] r_a, r_d;
  initial begin
    m_if.resp  = 1'b0;
    m_if.rdata = '0;
    forever begin
      if (rstn && m_if.req === 1'b1 && m_if.fault !== 1'b1) begin
        r_w = m_if.w_rb;
        r_a = m_if.addr;
        r_d = m_if.wdata;
        repeat (rdelay) @(negedge clk);
        if (r_w) mem[r_a] = r_d;
        else m_if.rdata = mem.exists(r_a) ? mem[r_a] : 32'hBAD0BAD0;
        m_if.resp = 1'b1;
        @(negedge clk);
        m_if.resp = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  // initiator monitor
  always @(negedge clk) begin
    if (rstn && m_if.req === 1'b1) begin
      if (exp_m.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL m_req_unexpected: addr %h w_rb %b, none expected",
                 m_if.addr, m_if.w_rb);
      end else begin
        me = exp_m.pop_front();
        chk("m_w_rb", {31'b0, m_if.w_rb}, {31'b0, me.w});
        chk("m_addr", m_if.addr, me.addr);
        chk("m_acc", {30'b0, m_if.acc}, {30'b0, BUS_ACC_4B});
        if (me.w) chk("m_wdata", m_if.wdata, me.data);
      end
    end
  end

  // config response monitor
  always @(negedge clk) begin
    if (rstn && s_if.resp === 1'b1) begin
      if (exp_s.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL s_resp_unexpected: rdata %h, none expected",
                 s_if.rdata);
      end else begin
        se = exp_s.pop_front();
        if (se.rd) chk("s_rdata", s_if.rdata, se.data);
      end
    end
  end

  // hold checker: request fields stable until response
  logic        pend = 1'b0;
  logic        p_w;
  logic [31:0] p_a, p_d;
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pend = 1'b0;
      end else if (pend) begin
        chk("hold_req_low", {31'b0, m_if.req}, 32'h0);
        chk("hold_addr", m_if.addr, p_a);
        chk("hold_w_rb", {31'b0, m_if.w_rb}, {31'b0, p_w});
        if (p_w) chk("hold_wdata", m_if.wdata, p_d);
        if (m_if.resp) pend = 1'b0;
      end else if (m_if.req === 1'b1 && m_if.fault !== 1'b1) begin
        pend = 1'b1;
        p_w  = m_if.w_rb;
        p_a  = m_if.addr;
        p_d  = m_if.wdata;
      end
    end
  end

  task automatic cfg_acc(input logic w, input logic [3:0] a,
                         input logic [31:0] d, input logic [31:0] exp);
    @(negedge clk);
    s_if.req   = 1'b1;
    s_if.w_rb  = w;
    s_if.addr  = a;
    s_if.acc   = BUS_ACC_4B;
    s_if.wdata = d;
    exp_s.push_back({~w, exp});
    #1 chk("s_fault_valid", {31'b0, s_if.fault}, 32'h0);
    @(negedge clk);
    s_if.req = 1'b0;
  endtask

  task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
    cfg_acc(1'b1, a, d, 32'h0);
  endtask

  task automatic cfg_rd(input logic [3:0] a, input logic [31:0] exp);
    cfg_acc(1'b0, a, 32'h0, exp);
  endtask

  task automatic cfg_bad(input logic [3:0] a, input logic [1:0] acc);
    @(negedge clk);
    s_if.req   = 1'b1;
    s_if.w_rb  = 1'b1;
    s_if.addr  = a;
    s_if.acc   = acc;
    s_if.wdata = 32'hFFFF_FFFF;
    #1 chk("s_fault_bad", {31'b0, s_if.fault}, 32'h1);
    @(negedge clk);
    s_if.req = 1'b0;
    chk("s_resp_bad", {31'b0, s_if.resp}, 32'h0);
  endtask

  task automatic push_m(input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    exp_m.push_back({w, a, d});
  endtask

  task automatic wait_int(input string nm, input int bound,
                          output int cnt);
    cnt = 0;
    while (dma_int !== 1'b1 && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
    chk(nm, {31'b0, dma_int}, 32'h1);
  endtask

  int cnt;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    s_if.req   = 1'b0;
    s_if.w_rb  = 1'b0;
    s_if.addr  = '0;
    s_if.acc   = BUS_ACC_4B;
    s_if.wdata = '0;
    mem[32'h100] = 32'h1111_1111;
    mem[32'h104] = 32'h2222_2222;
    mem[32'h108] = 32'h3333_3333;
    repeat (3) @(negedge clk);
    chk("rst_m_req", {31'b0, m_if.req}, 32'h0);
    chk("rst_m_addr", m_if.addr, 32'h0);
    chk("rst_m_wdata", m_if.wdata, 32'h0);
    chk("rst_m_acc", {30'b0, m_if.acc}, {30'b0, BUS_ACC_4B});
    chk("rst_dma_int", {31'b0, dma_int}, 32'h0);
    chk("rst_s_resp", {31'b0, s_if.resp}, 32'h0);
    chk("rst_s_rdata", s_if.rdata, 32'h0);
    rstn = 1'b1;
    cfg_rd(DMA_CTRL, 32'h0);
    cfg_rd(DMA_SRC, 32'h0);

    // three-word copy, 1-cycle responder
    cfg_wr(DMA_SRC, 32'h103);
    cfg_wr(DMA_DST, 32'h200);
    cfg_wr(DMA_LEN, 32'h3);
    cfg_rd(DMA_SRC, 32'h100);
    push_m(1'b0, 32'h100, 0);
    push_m(1'b1, 32'h200, 32'h1111_1111);
    push_m(1'b0, 32'h104, 0);
    push_m(1'b1, 32'h204, 32'h2222_2222);
    push_m(1'b0, 32'h108, 0);
    push_m(1'b1, 32'h208, 32'h3333_3333);
    cfg_wr(DMA_CTRL, 32'h1);
    wait_int("copy_done_int", 100, cnt);
    chk("copy_latency", cnt, 12);
    cfg_rd(DMA_CTRL, 32'h2);
    cfg_rd(DMA_LEN, 32'h0);
    cfg_rd(DMA_SRC, 32'h10C);
    cfg_rd(DMA_DST, 32'h20C);
    chk("mem_200", mem[32'h200], 32'h1111_1111);
    chk("mem_208", mem[32'h208], 32'h3333_3333);

    // CLR, then START with LEN=0
    cfg_wr(DMA_CTRL, 32'h2);
    chk("clr_int_low", {31'b0, dma_int}, 32'h0);
    cfg_rd(DMA_CTRL, 32'h0);
    cfg_wr(DMA_CTRL, 32'h1);
    chk("len0_int", {31'b0, dma_int}, 32'h1);
    cfg_rd(DMA_CTRL, 32'h2);

    // read fault on the second word
    cfg_wr(DMA_CTRL, 32'h2);
    chk("clr2_int_low", {31'b0, dma_int}, 32'h0);
    flt_en   = 1'b1;
    flt_addr = 32'h104;
    cfg_wr(DMA_SRC, 32'h100);
    cfg_wr(DMA_DST, 32'h300);
    cfg_wr(DMA_LEN, 32'h3);
    push_m(1'b0, 32'h100, 0);
    push_m(1'b1, 32'h300, 32'h1111_1111);
    push_m(1'b0, 32'h104, 0);
    cfg_wr(DMA_CTRL, 32'h1);
    wait_int("fault_int", 100, cnt);
    repeat (4) @(negedge clk);
    cfg_rd(DMA_CTRL, 32'h4);
    cfg_rd(DMA_SRC, 32'h104);
    cfg_rd(DMA_DST, 32'h304);
    cfg_rd(DMA_LEN, 32'h2);
    cfg_wr(DMA_CTRL, 32'h2);
    chk("clr3_int_low", {31'b0, dma_int}, 32'h0);
    cfg_rd(DMA_CTRL, 32'h0);
    flt_en = 1'b0;

    // slow responder, writes while busy
    rdelay = 5;
    cfg_wr(DMA_SRC, 32'h100);
    cfg_wr(DMA_DST, 32'h400);
    cfg_wr(DMA_LEN, 32'h2);
    push_m(1'b0, 32'h100, 0);
    push_m(1'b1, 32'h400, 32'h1111_1111);
    push_m(1'b0, 32'h104, 0);
    push_m(1'b1, 32'h404, 32'h2222_2222);
    cfg_wr(DMA_CTRL, 32'h1);
    cfg_wr(DMA_SRC, 32'hDEAD_0000);
    cfg_rd(DMA_CTRL, 32'h1);
    cfg_wr(DMA_CTRL, 32'h1);
    wait_int("slow_int", 200, cnt);
    cfg_rd(DMA_SRC, 32'h108);
    cfg_rd(DMA_DST, 32'h408);
    cfg_rd(DMA_LEN, 32'h0);
    cfg_rd(DMA_CTRL, 32'h2);
    chk("mem_404", mem[32'h404], 32'h2222_2222);
    cfg_wr(DMA_CTRL, 32'h2);

    // illegal config accesses
    cfg_bad(DMA_SRC, BUS_ACC_1B);
    cfg_bad(4'hD, BUS_ACC_4B);
    cfg_bad(4'h6, BUS_ACC_4B);
    cfg_rd(DMA_SRC, 32'h108);

    // reset during WR_WAIT, late response arrives in IDLE
    rdelay = 8;
    cfg_wr(DMA_SRC, 32'h100);
    cfg_wr(DMA_DST, 32'h500);
    cfg_wr(DMA_LEN, 32'h2);
    push_m(1'b0, 32'h100, 0);
    push_m(1'b1, 32'h500, 32'h1111_1111);
    cfg_wr(DMA_CTRL, 32'h1);
    cnt = 0;
    while (!(m_if.req === 1'b1 && m_if.w_rb === 1'b1) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("wr_req_seen", {31'b0, m_if.req}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("arst_m_req", {31'b0, m_if.req}, 32'h0);
    chk("arst_m_addr", m_if.addr, 32'h0);
    chk("arst_m_wdata", m_if.wdata, 32'h0);
    chk("arst_m_w_rb", {31'b0, m_if.w_rb}, 32'h0);
    chk("arst_s_rdata", s_if.rdata, 32'h0);
    chk("arst_dma_int", {31'b0, dma_int}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    chk("late_resp_int", {31'b0, dma_int}, 32'h0);
    cfg_rd(DMA_SRC, 32'h0);
    cfg_rd(DMA_DST, 32'h0);
    cfg_rd(DMA_LEN, 32'h0);
    cfg_rd(DMA_CTRL, 32'h0);

    repeat (5) @(negedge clk);
    chk("exp_m_drained", exp_m.size(), 0);
    chk("exp_s_drained", exp_s.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
